// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO geometry for the write and read pointer blocks
package fifo_pkg;

    localparam int FIFO_PTR_W    = 8;
    localparam int FIFO_DEPTH    = 90;
    localparam int FIFO_AF_LEVEL = 80;

    typedef enum logic [1:0] {
        PTR_HOLD    = 2'b00,
        PTR_INCR    = 2'b01,
        PTR_WRAP    = 2'b10
    } ptr_move_e;

endpackage

// File: rtl/bin2gray.sv
// rtl/bin2gray.sv - binary to Gray code converter shared by both pointer domains
module bin2gray
    import fifo_pkg::*;
#(
    parameter int N = FIFO_PTR_W
) (
    input  logic [N-1:0] bin_i,
    output logic [N-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/fifo_write_ctrl.sv
// rtl/fifo_write_ctrl.sv - write-side pointer, flags and occupancy for a non-power-of-two FIFO
module fifo_write_ctrl
    import fifo_pkg::*;
#(
    parameter int N        = FIFO_PTR_W,
    parameter int depth    = FIFO_DEPTH,
    parameter int AF_LEVEL = FIFO_AF_LEVEL
) (
    input  logic         wr_clk,
    input  logic         wr_rst,
    input  logic         wr_en,
    input  logic [N-1:0] rdPtr,
    output logic [N-1:0] wrPtr,
    output logic [N-1:0] wrPtr_gray,
    output logic [N-2:0] wr_addr,
    output logic         o_wr_we,
    output logic         o_fifo_full,
    output logic         o_almost_full,
    output logic [N-1:0] o_fill_count,
    output logic         o_overflow,
    output logic         o_wr_ack
);

    localparam logic [N-1:0] DEPTH_N   = N'(depth);
    localparam logic [N-1:0] AF_N      = N'(AF_LEVEL);
    localparam logic [N-2:0] LAST_ADDR = (N-1)'(depth - 1);

    logic [N-1:0] wr_ptr_q, wr_ptr_d;
    logic [N-1:0] gray_q, gray_d;
    logic         af_q, af_d;
    logic         ovf_q, ovf_d;
    logic         ack_q, ack_d;
    ptr_move_e    move;

    // Occupancy modulo 2^N; wrap bits differ means the writer is one lap ahead.
    function automatic logic [N-1:0] fill_of(input logic [N-1:0] wp, input logic [N-1:0] rp);
        logic [N-1:0] f;
        if (wp[N-1] == rp[N-1]) begin
            f = {1'b0, wp[N-2:0]} - {1'b0, rp[N-2:0]};
        end else begin
            f = DEPTH_N - {1'b0, rp[N-2:0]} + {1'b0, wp[N-2:0]};
        end
        return f;
    endfunction

    assign o_fifo_full = (wr_ptr_q[N-1] != rdPtr[N-1]) && (wr_ptr_q[N-2:0] == rdPtr[N-2:0]);
    assign o_wr_we     = wr_en & ~o_fifo_full & ~wr_rst;

    always_comb begin
        move = PTR_HOLD;
        if (o_wr_we) begin
            move = (wr_ptr_q[N-2:0] == LAST_ADDR) ? PTR_WRAP : PTR_INCR;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        unique case (move)
            PTR_INCR: wr_ptr_d = {wr_ptr_q[N-1], wr_ptr_q[N-2:0] + 1'b1};
            PTR_WRAP: wr_ptr_d = {~wr_ptr_q[N-1], {(N-1){1'b0}}};
            default:  wr_ptr_d = wr_ptr_q;
        endcase
    end

    // Gray is derived from the next pointer so both registers update on the same edge.
    bin2gray #(.N(N)) u_bin2gray (
        .bin_i  (wr_ptr_d),
        .gray_o (gray_d)
    );

    always_comb begin
        af_d  = fill_of(wr_ptr_d, rdPtr) >= AF_N;
        ovf_d = ovf_q | (wr_en & o_fifo_full);
        ack_d = o_wr_we;
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wr_ptr_q <= '0;
            gray_q   <= '0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            gray_q   <= gray_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
            ack_q    <= ack_d;
        end
    end

    assign wrPtr         = wr_ptr_q;
    assign wrPtr_gray    = gray_q;
    assign wr_addr       = wr_ptr_q[N-2:0];
    assign o_fill_count  = fill_of(wr_ptr_q, rdPtr);
    assign o_almost_full = af_q;
    assign o_overflow    = ovf_q;
    assign o_wr_ack      = ack_q;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
// tb/tb_fifo_write_ctrl.sv - directed self-checking bench for fifo_write_ctrl
module tb_fifo_write_ctrl;

    logic       wr_clk = 1'b0;
    logic       wr_rst;
    logic       wr_en;
    logic [7:0] rdPtr;
    logic [7:0] wrPtr;
    logic [7:0] wrPtr_gray;
    logic [6:0] wr_addr;
    logic       o_wr_we;
    logic       o_fifo_full;
    logic       o_almost_full;
    logic [7:0] o_fill_count;
    logic       o_overflow;
    logic       o_wr_ack;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_write_ctrl dut (
        .wr_clk        (wr_clk),
        .wr_rst        (wr_rst),
        .wr_en         (wr_en),
        .rdPtr         (rdPtr),
        .wrPtr         (wrPtr),
        .wrPtr_gray    (wrPtr_gray),
        .wr_addr       (wr_addr),
        .o_wr_we       (o_wr_we),
        .o_fifo_full   (o_fifo_full),
        .o_almost_full (o_almost_full),
        .o_fill_count  (o_fill_count),
        .o_overflow    (o_overflow),
        .o_wr_ack      (o_wr_ack)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [7:0] exp_ptr;

        wr_rst = 1'b1;
        wr_en  = 1'b1;
        rdPtr  = 8'h00;
        tick();
        tick();
        check("rst_wrptr",  wrPtr, 8'h00);
        check("rst_gray",   wrPtr_gray, 8'h00);
        check("rst_af",     o_almost_full, 1'b0);
        check("rst_ovf",    o_overflow, 1'b0);
        check("rst_ack",    o_wr_ack, 1'b0);
        check("rst_fill",   o_fill_count, 8'd0);
        check("rst_full",   o_fifo_full, 1'b0);
        check("rst_we_low", o_wr_we, 1'b0);

        wr_rst = 1'b0;
        settle();
        check("we_after_rst", o_wr_we, 1'b1);

        for (int i = 1; i <= 90; i++) begin
            tick();
            exp_ptr = (i == 90) ? 8'h80 : 8'(i);
            check($sformatf("fill_ptr_%0d", i),  wrPtr, exp_ptr);
            check($sformatf("fill_cnt_%0d", i),  o_fill_count, 8'(i));
            check($sformatf("fill_af_%0d", i),   o_almost_full, (i >= 80));
            check($sformatf("fill_full_%0d", i), o_fifo_full, (i == 90));
            check($sformatf("fill_ack_%0d", i),  o_wr_ack, 1'b1);
            if (i == 89) check("addr89_gray", wrPtr_gray, 8'h75);
        end
        wr_en = 1'b0;
        check("full_gray",  wrPtr_gray, 8'hC0);
        check("full_addr",  wr_addr, 7'd0);

        wr_en = 1'b1;
        settle();
        check("we_when_full", o_wr_we, 1'b0);
        tick();
        wr_en = 1'b0;
        check("ovf_ptr_hold", wrPtr, 8'h80);
        check("ovf_set",      o_overflow, 1'b1);
        check("ovf_no_ack",   o_wr_ack, 1'b0);
        tick();
        tick();
        check("ovf_sticky",   o_overflow, 1'b1);

        rdPtr = 8'h01;
        wr_en = 1'b1;
        settle();
        check("rd_adv_full", o_fifo_full, 1'b0);
        check("rd_adv_we",   o_wr_we, 1'b1);
        check("rd_adv_fill", o_fill_count, 8'd89);
        tick();
        wr_en = 1'b0;
        check("rd_adv_ptr",  wrPtr, 8'h81);
        check("rd_adv_gray", wrPtr_gray, 8'hC1);
        check("rd_adv_full2", o_fifo_full, 1'b1);
        check("rd_adv_fill2", o_fill_count, 8'd90);
        check("rd_adv_ack",  o_wr_ack, 1'b1);
        check("rd_adv_af",   o_almost_full, 1'b1);

        rdPtr = 8'h50;
        settle();
        check("lap_fill11", o_fill_count, 8'd11);
        check("lap_full",   o_fifo_full, 1'b0);
        tick();
        check("lap_af_clr", o_almost_full, 1'b0);
        check("lap_ack_clr", o_wr_ack, 1'b0);

        wr_en = 1'b1;
        tick();
        tick();
        tick();
        check("lap_ptr84",  wrPtr, 8'h84);
        check("lap_fill14", o_fill_count, 8'd14);
        rdPtr = 8'h83;
        settle();
        check("same_wrap_fill1", o_fill_count, 8'd1);

        rdPtr  = 8'h36;
        settle();
        check("pre_rst_fill40", o_fill_count, 8'd40);
        wr_rst = 1'b1;
        settle();
        check("mid_rst_we", o_wr_we, 1'b0);
        tick();
        check("mid_rst_ptr",  wrPtr, 8'h00);
        check("mid_rst_gray", wrPtr_gray, 8'h00);
        check("mid_rst_ack",  o_wr_ack, 1'b0);
        check("mid_rst_ovf",  o_overflow, 1'b0);
        check("mid_rst_af",   o_almost_full, 1'b0);

        wr_rst = 1'b0;
        wr_en  = 1'b0;
        rdPtr  = 8'h00;
        settle();
        check("post_rst_fill", o_fill_count, 8'd0);
        check("post_rst_full", o_fifo_full, 1'b0);

        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        check("single_ptr", wrPtr, 8'h01);
        check("single_ack", o_wr_ack, 1'b1);
        tick();
        check("single_ack_drop", o_wr_ack, 1'b0);
        check("single_hold",     wrPtr, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_write_ctrl.md
FIFO_WRITE_CTRL -- requirements
Module: fifo_write_ctrl

Interface
REQ-001 Parameter N, default 8: pointer width; bit N-1 is the wrap bit, bits N-2:0 are the address.
REQ-002 Parameter depth, default 8'b0101_1010 (90): number of FIFO locations; SHALL satisfy 2 <= depth <= 2^(N-1).
REQ-003 Parameter AF_LEVEL, default 8'd80: almost-full threshold in entries; SHALL satisfy 1 <= AF_LEVEL <= depth.
REQ-004 wr_clk  input  1: the single clock; all state changes on its rising edge.
REQ-005 wr_rst  input  1: reset, synchronous and active-high.
REQ-006 wr_en  input  1: write request for the current cycle.
REQ-007 rdPtr  input  N: read pointer from the read side, same encoding as wrPtr, stable within the wr_clk domain.
REQ-008 wrPtr  output  N: registered write pointer (wrap bit plus address).
REQ-009 wrPtr_gray  output  N: registered Gray code of wrPtr, for crossing to the read side.
REQ-010 wr_addr  output  N-1: RAM write address, equal to wrPtr[N-2:0].
REQ-011 o_wr_we  output  1: combinational RAM write strobe, equal to wr_en & ~o_fifo_full & ~wr_rst.
REQ-012 o_fifo_full  output  1: combinational full flag.
REQ-013 o_almost_full  output  1: registered flag, high when o_fill_count >= AF_LEVEL.
REQ-014 o_fill_count  output  N: combinational occupancy, 0..depth.
REQ-015 o_overflow  output  1: sticky error, set by a write attempted while full.
REQ-016 o_wr_ack  output  1: registered pulse, high one cycle after each accepted write.

Function
REQ-017 Full SHALL be asserted when wrPtr[N-1] != rdPtr[N-1] and wrPtr[N-2:0] == rdPtr[N-2:0].
REQ-018 A write SHALL be accepted when o_wr_we = 1; o_wr_we is the only condition that advances wrPtr.
REQ-019 On an accepted write with wrPtr[N-2:0] < depth-1: address increments by 1 and the wrap bit holds.
REQ-020 On an accepted write with wrPtr[N-2:0] == depth-1: address becomes 0 and the wrap bit toggles.
REQ-021 When no write is accepted, wrPtr, wrPtr_gray and wr_addr SHALL hold their values.
REQ-022 o_fill_count = wr_addr - rdPtr[N-2:0] when the wrap bits are equal; otherwise depth - rdPtr[N-2:0] + wr_addr; computed at N+1 bits and truncated to N bits.
REQ-023 wrPtr_gray SHALL equal wrPtr ^ (wrPtr >> 1) in the same cycle that wrPtr updates (zero-cycle skew between the two).
REQ-024 A write attempt while full (wr_en = 1, o_fifo_full = 1) SHALL be dropped, leaving wrPtr unchanged, and SHALL set o_overflow on the next edge; o_overflow clears only on reset.
REQ-025 o_almost_full SHALL be evaluated from the pointer values after the current edge: next-cycle fill >= AF_LEVEL.
REQ-026 o_wr_ack SHALL be 1 in the cycle after an accepted write and 0 otherwise; back-to-back writes give a continuous high.
REQ-027 A read-side pointer advance while the block is full SHALL clear o_fifo_full combinationally in the same cycle; a write in that cycle is then accepted.

Reset
REQ-028 While wr_rst = 1 at a rising edge: wrPtr, wrPtr_gray, o_almost_full, o_overflow and o_wr_ack SHALL become 0.
REQ-029 wr_rst SHALL take priority over wr_en; o_wr_we SHALL be 0 while wr_rst = 1.
REQ-030 Reset asserted mid-stream SHALL discard all occupancy; the first cycle after reset shows o_fill_count = rdPtr-relative value, with the read side reset concurrently giving 0.

Structure
REQ-031 depth, AF_LEVEL and the default N SHALL live in a shared package `fifo_pkg`, also used by the read-side block.
REQ-032 The Gray conversion SHALL be a sub-module `bin2gray` (parameter N), reusable by the read side.
REQ-033 All flops SHALL be in the wr_clk domain; no latches.

Verification
REQ-034 Reset, then 90 writes with rdPtr = 0: wrPtr = 8'h80, o_fifo_full = 1, o_fill_count = 90, o_almost_full = 1 from the 80th write.
REQ-035 When full, wr_en = 1 for 1 cycle: wrPtr stays 8'h80, o_overflow = 1 and remains 1 until wr_rst.
REQ-036 wrPtr = 8'h59 (address 89), one write: wrPtr = 8'h80, wrPtr_gray = 8'hC0.
REQ-037 Full at wrPtr = 8'h80, rdPtr = 8'h00; rdPtr changes to 8'h01 and wr_en = 1 in the same cycle: write accepted, wrPtr = 8'h81, o_fifo_full stays 1.
REQ-038 wr_rst raised with o_fill_count = 40 and wr_en = 1 held: next edge gives wrPtr = 0, o_wr_ack = 0, o_overflow = 0, and o_wr_we = 0 during reset.
